// File: rtl/multi_channel_edge_detect.sv
// Multi-channel line edge detector: per-channel synchroniser, glitch filter,
// edge pulses, mode-gated sticky flags and saturating edge counters.
module multi_channel_edge_detect #(
    parameter int   NUM_CH      = 2,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILTER_LEN  = 3,
    parameter int   CNT_W       = 4,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_CH-1:0]       din,
    input  logic [1:0]              mode,
    input  logic                    clear,
    output logic [NUM_CH-1:0]       level,
    output logic [NUM_CH-1:0]       rise_pulse,
    output logic [NUM_CH-1:0]       fall_pulse,
    output logic [NUM_CH-1:0]       edge_pulse,
    output logic [NUM_CH-1:0]       sticky,
    output logic [NUM_CH*CNT_W-1:0] edge_count
);

    // Filter counter only needs to reach FILTER_LEN-1; keep at least one bit.
    localparam int              FC_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    logic [FC_W-1:0]   fcnt_q [NUM_CH];
    logic [FC_W-1:0]   fcnt_d [NUM_CH];
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [NUM_CH-1:0] sync_s;

    always_comb begin
        sync_d[0] = din;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Level only follows the synchronised line after FILTER_LEN consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fcnt_d[i] = fcnt_q[i];
            if (sync_s[i] == level_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FC_LAST) begin
                level_d[i] = sync_s[i];
                fcnt_d[i]  = '0;
                rise_d[i]  = sync_s[i];
                fall_d[i]  = ~sync_s[i];
            end else begin
                fcnt_d[i] = fcnt_q[i] + FC_W'(1);
            end
        end
    end

    assign edge_pulse = (rise_q & {NUM_CH{mode[0]}}) | (fall_q & {NUM_CH{mode[1]}});

    // A clear coinciding with an edge still records that edge.
    always_comb begin
        sticky_d = edge_pulse | (sticky_q & ~{NUM_CH{clear}});
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = count_q[i];
            if (clear) begin
                count_d[i] = edge_pulse[i] ? CNT_W'(1) : '0;
            end else if (edge_pulse[i] && (count_q[i] != CNT_MAX)) begin
                count_d[i] = count_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {NUM_CH{RESET_LEVEL}};
            end
            for (int i = 0; i < NUM_CH; i++) begin
                fcnt_q[i]  <= '0;
                count_q[i] <= '0;
            end
            level_q  <= {NUM_CH{RESET_LEVEL}};
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                fcnt_q[i]  <= fcnt_d[i];
                count_q[i] <= count_d[i];
            end
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign sticky     = sticky_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign edge_count[g*CNT_W +: CNT_W] = count_q[g];
    end

endmodule

// File: tb/tb_multi_channel_edge_detect.sv
// Bench for multi_channel_edge_detect: history-window reference model feeding
// a per-cycle scoreboard, a vector table and hand-written corner sequences.
module tb_multi_channel_edge_detect;

    localparam int NCH = 2;
    localparam int SS  = 2;
    localparam int FL  = 3;
    localparam int CW  = 4;

    logic                clk;
    logic                n_rst;
    logic [NCH-1:0]      din;
    logic [1:0]          mode;
    logic                clear;
    logic [NCH-1:0]      level;
    logic [NCH-1:0]      rise_pulse;
    logic [NCH-1:0]      fall_pulse;
    logic [NCH-1:0]      edge_pulse;
    logic [NCH-1:0]      sticky;
    logic [NCH*CW-1:0]   edge_count;

    multi_channel_edge_detect #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .FILTER_LEN(FL), .CNT_W(CW), .RESET_LEVEL(1'b1)
    ) dut (
        .clk(clk), .n_rst(n_rst), .din(din), .mode(mode), .clear(clear),
        .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .edge_pulse(edge_pulse), .sticky(sticky), .edge_count(edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0]    level;
        logic [NCH-1:0]    rise;
        logic [NCH-1:0]    fall;
        logic [NCH-1:0]    ep;
        logic [NCH-1:0]    sticky;
        logic [NCH*CW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic [NCH-1:0]    din;
        logic [1:0]        mode;
        logic              clear;
        int                cycles;
        logic [NCH-1:0]    level;
        logic [NCH-1:0]    sticky;
        logic [NCH*CW-1:0] cnt;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[9];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: level flips once the last FL synchronised samples all
    // disagree with it.
    logic [NCH-1:0] m_sync [SS];
    logic [NCH-1:0] m_hist [FL];
    logic [NCH-1:0] m_level, m_rise, m_fall, m_sticky;
    int             m_cnt [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_sync[k] = '1;
        for (int k = 0; k < FL; k++) m_hist[k] = '1;
        m_level  = '1;
        m_rise   = '0;
        m_fall   = '0;
        m_sticky = '0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    endtask

    function automatic logic [NCH*CW-1:0] model_cnt_vec();
        logic [NCH*CW-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
        return v;
    endfunction

    task automatic model_clock(input logic [NCH-1:0] d, input logic [1:0] m, input logic c);
        logic [NCH-1:0] ep;
        logic [NCH-1:0] s;
        logic           all_diff;
        exp_t           e;
        ep = (m_rise & {NCH{m[0]}}) | (m_fall & {NCH{m[1]}});
        for (int i = 0; i < NCH; i++) begin
            if (ep[i]) begin
                m_sticky[i] = 1'b1;
                if (c) m_cnt[i] = 1;
                else if (m_cnt[i] < (1 << CW) - 1) m_cnt[i] = m_cnt[i] + 1;
            end else if (c) begin
                m_sticky[i] = 1'b0;
                m_cnt[i]    = 0;
            end
        end
        s = m_sync[SS-1];
        for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = d;
        for (int k = FL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < NCH; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < FL; k++) if (m_hist[k][i] == m_level[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                m_rise[i]  = m_level[i];
                m_fall[i]  = ~m_level[i];
            end
        end
        e.level  = m_level;
        e.rise   = m_rise;
        e.fall   = m_fall;
        e.ep     = (m_rise & {NCH{m[0]}}) | (m_fall & {NCH{m[1]}});
        e.sticky = m_sticky;
        e.cnt    = model_cnt_vec();
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("level",      32'(level),      32'(e.level));
        check("rise_pulse", 32'(rise_pulse), 32'(e.rise));
        check("fall_pulse", 32'(fall_pulse), 32'(e.fall));
        check("edge_pulse", 32'(edge_pulse), 32'(e.ep));
        check("sticky",     32'(sticky),     32'(e.sticky));
        check("edge_count", 32'(edge_count), 32'(e.cnt));
    endtask

    // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
    task automatic applyStimulus(input logic [NCH-1:0] d, input logic [1:0] m, input logic c);
        @(negedge clk);
        din   = d;
        mode  = m;
        clear = c;
        @(posedge clk);
        model_clock(d, m, c);
        #1;
        checkOutput();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},  32'(level),      32'h3);
        check({tag, "_rise"},   32'(rise_pulse), 32'h0);
        check({tag, "_fall"},   32'(fall_pulse), 32'h0);
        check({tag, "_sticky"}, 32'(sticky),     32'h0);
        check({tag, "_count"},  32'(edge_count), 32'h0);
    endtask

    initial begin
        logic [NCH-1:0] d;

        tbl[0] = '{din: 2'b11, mode: 2'b00, clear: 1'b0, cycles: 10, level: 2'b11, sticky: 2'b00, cnt: 8'h00};
        tbl[1] = '{din: 2'b10, mode: 2'b10, clear: 1'b0, cycles: 8,  level: 2'b10, sticky: 2'b01, cnt: 8'h01};
        tbl[2] = '{din: 2'b00, mode: 2'b10, clear: 1'b0, cycles: 2,  level: 2'b10, sticky: 2'b01, cnt: 8'h01};
        tbl[3] = '{din: 2'b10, mode: 2'b10, clear: 1'b0, cycles: 8,  level: 2'b10, sticky: 2'b01, cnt: 8'h01};
        tbl[4] = '{din: 2'b00, mode: 2'b10, clear: 1'b0, cycles: 3,  level: 2'b10, sticky: 2'b01, cnt: 8'h01};
        tbl[5] = '{din: 2'b10, mode: 2'b10, clear: 1'b0, cycles: 8,  level: 2'b10, sticky: 2'b11, cnt: 8'h11};
        tbl[6] = '{din: 2'b11, mode: 2'b00, clear: 1'b1, cycles: 8,  level: 2'b11, sticky: 2'b00, cnt: 8'h00};
        tbl[7] = '{din: 2'b10, mode: 2'b01, clear: 1'b0, cycles: 8,  level: 2'b10, sticky: 2'b00, cnt: 8'h00};
        tbl[8] = '{din: 2'b11, mode: 2'b11, clear: 1'b0, cycles: 8,  level: 2'b11, sticky: 2'b01, cnt: 8'h01};

        din   = 2'b11;
        mode  = 2'b00;
        clear = 1'b0;
        n_rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #2;
        n_rst = 1'b1;

        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < tbl[r].cycles; c++) begin
                applyStimulus(tbl[r].din, tbl[r].mode, tbl[r].clear);
            end
            check($sformatf("row%0d_level", r),  32'(level),      32'(tbl[r].level));
            check($sformatf("row%0d_sticky", r), 32'(sticky),     32'(tbl[r].sticky));
            check($sformatf("row%0d_count", r),  32'(edge_count), 32'(tbl[r].cnt));
        end

        // Twenty filtered edges in both-edge mode drive ch0's counter into saturation.
        d = 2'b11;
        for (int n = 0; n < 20; n++) begin
            d[0] = ~d[0];
            repeat (6) applyStimulus(d, 2'b11, 1'b0);
        end
        check("sat_count", 32'(edge_count), 32'h0F);
        check("sat_sticky", 32'(sticky), 32'h1);

        d[0] = ~d[0];
        repeat (4) applyStimulus(d, 2'b11, 1'b0);
        check("latency_level_before", 32'(level[0]), 32'h1);
        applyStimulus(d, 2'b11, 1'b0);
        check("latency_level_after", 32'(level[0]), 32'h0);
        check("latency_edge_pulse", 32'(edge_pulse[0]), 32'h1);
        applyStimulus(d, 2'b11, 1'b1);
        check("clear_with_edge_count", 32'(edge_count), 32'h01);
        check("clear_with_edge_sticky", 32'(sticky), 32'h1);
        applyStimulus(d, 2'b11, 1'b1);
        check("clear_alone_count", 32'(edge_count), 32'h00);
        check("clear_alone_sticky", 32'(sticky), 32'h0);

        // Async reset in the middle of a partial filter count on ch0.
        repeat (6) applyStimulus(2'b11, 2'b11, 1'b0);
        repeat (4) applyStimulus(2'b10, 2'b11, 1'b0);
        check("midfilter_level", 32'(level), 32'h3);
        @(negedge clk);
        n_rst = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check_reset_state("midreset");
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        repeat (4) applyStimulus(2'b10, 2'b11, 1'b0);
        check("postreset_no_early_fall", 32'(fall_pulse), 32'h0);
        applyStimulus(2'b10, 2'b11, 1'b0);
        check("postreset_fall", 32'(fall_pulse), 32'h1);
        check("postreset_level", 32'(level), 32'h2);
        applyStimulus(2'b10, 2'b11, 1'b0);
        check("postreset_fall_done", 32'(fall_pulse), 32'h0);
        check("postreset_count", 32'(edge_count), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
